mem_scheduler: RTL
==================

# mem_scheduler

Single-port ZBT memory scheduler between the capture path (NTSC writer), the display path (VGA reader) and a general processing port. Owns the triple-buffer rotation: capture, ready and display roles for three frame buffers. Issues one memory operation per `clock` cycle by fixed priority and keeps the sequential address counters for the streaming clients.

## Interface
Parameters:
- `LOG_MEM`, 36: memory word width, two 18-bit pixels per word.
- `LOG_ADDR`, 19: memory address width.
- `FRAME_WORDS`, 153600: words per 640x480 frame.

Ports:
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `frame_flag`  in  1  one-cycle pulse at display vertical blank.
- `vga_flag`  in  1  VGA read request, single cycle.
- `vga_pixel`  out  LOG_MEM  read data for VGA.
- `done_vga`  out  1  `vga_pixel` valid.
- `ntsc_flag`  in  1  NTSC write request; held until `done_ntsc`.
- `ntsc_pixel`  in  LOG_MEM  write data; held with `ntsc_flag`.
- `ntsc_frame_done`  in  1  pulse: last word of capture frame written.
- `done_ntsc`  out  1  NTSC write granted this cycle.
- `proc_flag`, `proc_we`  in  1 each  processing request and write enable.
- `proc_addr`  in  LOG_ADDR  absolute address; no bank offset.
- `proc_din`  in  LOG_MEM  processing write data.
- `done_proc`  out  1  processing request granted this cycle.
- `proc_dout`  out  LOG_MEM  processing read data.
- `proc_valid`  out  1  `proc_dout` valid.
- `mem_addr`  out  LOG_ADDR  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_din`  out  LOG_MEM  memory write data.
- `mem_dout`  in  LOG_MEM  memory read data; valid 2 cycles after the address cycle.

## Operation
- **Grant logic.** Combinational, one grant per cycle. Priority is VGA, then NTSC, then processing. VGA issues at most one request every third cycle, so NTSC is never starved. Processing receives leftover cycles only.
- **VGA grant.** `mem_addr` = display base + `vga_addr`, with `mem_we`=0. Then `vga_addr`++, wrapping from FRAME_WORDS-1 to 0.
- **NTSC grant.** `mem_addr` = capture base + `ntsc_addr`, with `mem_we`=1 and `mem_din`=`ntsc_pixel`. `done_ntsc`=1 in the same cycle. Then `ntsc_addr`++, with the same wrap.
- **Processing grant.** `mem_addr`=`proc_addr`, `mem_we`=`proc_we`, `mem_din`=`proc_din`. `done_proc`=1 in the same cycle.
- **Idle cycle.** `mem_we`=0 and `mem_addr` holds its last value.
- **Read return.** A 2-stage tag shift register (none/vga/proc) steers `mem_dout` to the requester. `vga_pixel`/`done_vga` or `proc_dout`/`proc_valid` are asserted exactly 2 cycles after the grant. Data registers hold their value when the valid signal is low.
- **Roles.** Three 2-bit role registers: D (display), C (capture), R (ready), plus a `ready_valid` flag. Bank base = role × FRAME_WORDS.
- **`ntsc_frame_done`.** Swap C and R; set `ready_valid`; clear `ntsc_addr`.
- **`frame_flag`.** If `ready_valid`: swap D and R and clear `ready_valid`. In all cases clear `vga_addr`.
- **Both pulses in the same cycle.** Apply the frame_done swap first, then frame_flag. Result: D'=old C, C'=old R, R'=old D, `ready_valid`=0.
- **Rotation vs. counters.** A grant in the same cycle as a rotation uses the pre-rotation base. The counter clear overrides that grant's increment.
- **In-flight reads** are never flushed by rotation; they still return with their done/valid signal.

## Timing
- **Reset values:** all done/valid outputs 0; `vga_pixel`, `proc_dout`, `mem_addr`, `mem_din` = 0; `mem_we`=0.
- **Roles after reset:** D=0, C=1, R=2; `ready_valid`=0; both counters 0; tags cleared.
- **Latency:** write done in the same cycle as the grant; read latency 2 cycles.
- **Mid-operation reset:** clears the tag pipeline, so no done/valid pulse fires after reset even if a read was in flight.

## Structure
- Add `FRAME_WORDS` and `LOG_ADDR` to `params.v`, together with the existing `LOG_MEM`.
- Also add the tag encodings (`TAG_NONE`, `TAG_VGA`, `TAG_PROC`) to `params.v`.
- Sub-module `buffer_rotator` holds D/C/R and `ready_valid`, with the swap ordering above. It outputs the three bank bases.

## Test plan
- **Basic VGA read:** after reset, pulse `vga_flag` at t=10 → `mem_addr`=0 and `mem_we`=0 at t=10; `done_vga`=1 at t=12 with `vga_pixel`=`mem_dout`(t=12).
- **VGA/NTSC contention:** `vga_flag` and `ntsc_flag` both high → VGA granted first; `done_ntsc`=1 the next cycle with `mem_addr`=153600+0 and `mem_din`=`ntsc_pixel`.
- **NTSC wrap:** 153600 NTSC writes → last address 307199, next address 153600.
- **Full rotation:** `ntsc_frame_done` then `frame_flag` → VGA reads start at base 153600 and NTSC writes at base 307200; a second `frame_flag` with no new frame_done keeps D=1.
- **Simultaneous pulses:** `ntsc_frame_done` and `frame_flag` in the same cycle → D=1, C=2, R=0, `ready_valid`=0.
- **Processing port and reset:** proc read at addr 5 in an idle cycle → `proc_valid` 2 cycles later. Assert `reset` 1 cycle after the grant → no `proc_valid` is ever asserted.

Source files
------------

// File: rtl/mem_scheduler_pkg.sv
// Shared widths, frame geometry and encodings for the ZBT memory scheduler.
// Pixel words carry two 18-bit pixels.
package mem_scheduler_pkg;

    localparam int LOG_MEM     = 36;
    localparam int LOG_ADDR    = 19;
    localparam int FRAME_WORDS = 153600;

    // Identifies which requester owns a read that is still in flight
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_PROC = 2'd2
    } tag_t;

    typedef enum logic [1:0] {
        GRANT_IDLE = 2'd0,
        GRANT_VGA  = 2'd1,
        GRANT_NTSC = 2'd2,
        GRANT_PROC = 2'd3
    } grant_t;

endpackage

// File: rtl/mem_scheduler_buffer_rotator.sv
// Triple-buffer role rotation between capture, ready and display banks.
// Emits the bank base address for each active role.
module buffer_rotator
    import mem_scheduler_pkg::*;
#(
    parameter int LOG_ADDR    = mem_scheduler_pkg::LOG_ADDR,
    parameter int FRAME_WORDS = mem_scheduler_pkg::FRAME_WORDS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_done,
    input  logic                frame_flag,
    output logic [LOG_ADDR-1:0] display_base,
    output logic [LOG_ADDR-1:0] capture_base
);

    logic [1:0] role_d, role_c, role_r;
    logic       ready_valid;

    logic [1:0] c_mid, r_mid;
    logic       rv_mid;
    logic [1:0] d_next, c_next, r_next;
    logic       rv_next;

    function automatic logic [LOG_ADDR-1:0] base_of(input logic [1:0] role);
        case (role)
            2'd1:    base_of = LOG_ADDR'(FRAME_WORDS);
            2'd2:    base_of = LOG_ADDR'(2 * FRAME_WORDS);
            default: base_of = '0;
        endcase
    endfunction

    // Frame-done swap is applied first so a same-cycle frame_flag sees the fresh ready bank
    always_comb begin
        c_mid  = role_c;
        r_mid  = role_r;
        rv_mid = ready_valid;
        if (frame_done) begin
            c_mid  = role_r;
            r_mid  = role_c;
            rv_mid = 1'b1;
        end
        d_next  = role_d;
        c_next  = c_mid;
        r_next  = r_mid;
        rv_next = rv_mid;
        if (frame_flag && rv_mid) begin
            d_next  = r_mid;
            r_next  = role_d;
            rv_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            role_d      <= 2'd0;
            role_c      <= 2'd1;
            role_r      <= 2'd2;
            ready_valid <= 1'b0;
        end else begin
            role_d      <= d_next;
            role_c      <= c_next;
            role_r      <= r_next;
            ready_valid <= rv_next;
        end
    end

    assign display_base = base_of(role_d);
    assign capture_base = base_of(role_c);

endmodule

// File: rtl/mem_scheduler.sv
// Single-port ZBT scheduler: VGA reads, NTSC writes and a processing port
// share one memory operation per clock by fixed priority.
module mem_scheduler
    import mem_scheduler_pkg::*;
#(
    parameter int LOG_MEM     = mem_scheduler_pkg::LOG_MEM,
    parameter int LOG_ADDR    = mem_scheduler_pkg::LOG_ADDR,
    parameter int FRAME_WORDS = mem_scheduler_pkg::FRAME_WORDS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_flag,
    input  logic                vga_flag,
    output logic [LOG_MEM-1:0]  vga_pixel,
    output logic                done_vga,
    input  logic                ntsc_flag,
    input  logic [LOG_MEM-1:0]  ntsc_pixel,
    input  logic                ntsc_frame_done,
    output logic                done_ntsc,
    input  logic                proc_flag,
    input  logic                proc_we,
    input  logic [LOG_ADDR-1:0] proc_addr,
    input  logic [LOG_MEM-1:0]  proc_din,
    output logic                done_proc,
    output logic [LOG_MEM-1:0]  proc_dout,
    output logic                proc_valid,
    output logic [LOG_ADDR-1:0] mem_addr,
    output logic                mem_we,
    output logic [LOG_MEM-1:0]  mem_din,
    input  logic [LOG_MEM-1:0]  mem_dout
);

    grant_t              grant;
    tag_t                tag_1, tag_2;
    logic [LOG_ADDR-1:0] vga_addr, ntsc_addr;
    logic [LOG_ADDR-1:0] last_addr;
    logic [LOG_MEM-1:0]  last_din;
    logic [LOG_MEM-1:0]  vga_hold, proc_hold;
    logic [LOG_ADDR-1:0] display_base, capture_base;

    buffer_rotator #(
        .LOG_ADDR    (LOG_ADDR),
        .FRAME_WORDS (FRAME_WORDS)
    ) rotator (
        .clock        (clock),
        .reset        (reset),
        .frame_done   (ntsc_frame_done),
        .frame_flag   (frame_flag),
        .display_base (display_base),
        .capture_base (capture_base)
    );

    function automatic logic [LOG_ADDR-1:0] wrap_inc(input logic [LOG_ADDR-1:0] count);
        if (count == LOG_ADDR'(FRAME_WORDS - 1))
            wrap_inc = '0;
        else
            wrap_inc = count + 1'b1;
    endfunction

    always_comb begin
        grant = GRANT_IDLE;
        if (vga_flag)
            grant = GRANT_VGA;
        else if (ntsc_flag)
            grant = GRANT_NTSC;
        else if (proc_flag)
            grant = GRANT_PROC;
    end

    // Idle cycles replay the last address/data so the bus stays quiet
    always_comb begin
        mem_addr  = last_addr;
        mem_we    = 1'b0;
        mem_din   = last_din;
        done_ntsc = 1'b0;
        done_proc = 1'b0;
        case (grant)
            GRANT_VGA: begin
                mem_addr = display_base + vga_addr;
            end
            GRANT_NTSC: begin
                mem_addr  = capture_base + ntsc_addr;
                mem_we    = 1'b1;
                mem_din   = ntsc_pixel;
                done_ntsc = 1'b1;
            end
            GRANT_PROC: begin
                mem_addr  = proc_addr;
                mem_we    = proc_we;
                mem_din   = proc_din;
                done_proc = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_addr <= '0;
            last_din  <= '0;
        end else begin
            if (grant != GRANT_IDLE)
                last_addr <= mem_addr;
            if (grant == GRANT_NTSC || grant == GRANT_PROC)
                last_din <= mem_din;
        end
    end

    // Rotation pulses clear the counters even when a grant would advance them
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_addr  <= '0;
            ntsc_addr <= '0;
        end else begin
            if (frame_flag)
                vga_addr <= '0;
            else if (grant == GRANT_VGA)
                vga_addr <= wrap_inc(vga_addr);

            if (ntsc_frame_done)
                ntsc_addr <= '0;
            else if (grant == GRANT_NTSC)
                ntsc_addr <= wrap_inc(ntsc_addr);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_1     <= TAG_NONE;
            tag_2     <= TAG_NONE;
            vga_hold  <= '0;
            proc_hold <= '0;
        end else begin
            if (grant == GRANT_VGA)
                tag_1 <= TAG_VGA;
            else if (grant == GRANT_PROC && !proc_we)
                tag_1 <= TAG_PROC;
            else
                tag_1 <= TAG_NONE;
            tag_2 <= tag_1;
            if (tag_2 == TAG_VGA)
                vga_hold <= mem_dout;
            if (tag_2 == TAG_PROC)
                proc_hold <= mem_dout;
        end
    end

    // Returned data is steered straight through in its valid cycle, then held
    assign done_vga   = (tag_2 == TAG_VGA);
    assign proc_valid = (tag_2 == TAG_PROC);
    assign vga_pixel  = done_vga   ? mem_dout : vga_hold;
    assign proc_dout  = proc_valid ? mem_dout : proc_hold;

endmodule
